// File: rtl/hub75_column_driver.sv
// HUB75 column driver: requests a column pair, shifts it into a 64x64 1/32-scan
// panel and displays it with 3-plane binary-coded modulation.
module hub75_column_driver #(
  parameter int unsigned NUM_ROWS    = 64,
  parameter int unsigned SCAN_RATE   = 32,
  parameter int unsigned RGB_RES     = 9,
  parameter int unsigned BCM_BASE    = 16,
  parameter int unsigned REQ_TIMEOUT = 256
) (
  input  logic                                      clk_in,
  input  logic                                      rst_in,
  input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]     columns,
  input  logic [$clog2(SCAN_RATE)-1:0]              col_num1,
  input  logic                                      data_valid,
  output logic                                      hub75_ready,
  output logic [$clog2(SCAN_RATE)-1:0]              hub75_addr,
  output logic [2:0]                                hub75_rgb0,
  output logic [2:0]                                hub75_rgb1,
  output logic                                      hub75_clk,
  output logic                                      hub75_latch,
  output logic                                      hub75_oe_n
);

  localparam int unsigned AW = $clog2(SCAN_RATE);
  localparam int unsigned PW = $clog2(NUM_ROWS);
  localparam int unsigned TW = $clog2(REQ_TIMEOUT);
  localparam int unsigned DW = $clog2((BCM_BASE << 2) + 1);
  localparam int unsigned CB = RGB_RES / 3;
  localparam int unsigned IW = $clog2(RGB_RES);

  localparam logic [PW-1:0] PIX_LAST = PW'(NUM_ROWS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(REQ_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_SHIFT,
    S_LATCH,
    S_DISPLAY
  } state_t;

  state_t                                  state;
  logic [PW-1:0]                           pix;
  logic                                    phase;
  logic [1:0]                              plane;
  logic [TW-1:0]                           to_cnt;
  logic [DW-1:0]                           disp_cnt;
  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]   col_buf;
  logic [AW-1:0]                           addr_buf;

  logic                                    capture_c;
  logic [RGB_RES-1:0]                      px0_c;
  logic [RGB_RES-1:0]                      px1_c;
  logic [IW-1:0]                           r_idx_c;
  logic [IW-1:0]                           g_idx_c;
  logic [IW-1:0]                           b_idx_c;
  logic [DW-1:0]                           disp_last_c;

  // Current pixel and the bit of each colour field selected by the BCM plane
  always_comb begin
    capture_c   = (state == S_WAIT) && data_valid;
    px0_c       = col_buf[0][pix];
    px1_c       = col_buf[1][pix];
    r_idx_c     = IW'(2 * CB) + IW'(plane);
    g_idx_c     = IW'(CB) + IW'(plane);
    b_idx_c     = IW'(plane);
    disp_last_c = DW'((BCM_BASE << plane) - 1);
  end

  // Pair buffer; only loaded while waiting, so stray strobes never disturb it
  always_ff @(posedge clk_in) begin
    if (capture_c) begin
      col_buf  <= columns;
      addr_buf <= col_num1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= S_REQ;
      pix         <= '0;
      phase       <= 1'b0;
      plane       <= '0;
      to_cnt      <= '0;
      disp_cnt    <= '0;
      hub75_ready <= 1'b0;
      hub75_addr  <= '0;
      hub75_rgb0  <= '0;
      hub75_rgb1  <= '0;
      hub75_clk   <= 1'b0;
      hub75_latch <= 1'b0;
      hub75_oe_n  <= 1'b1;
    end else begin
      hub75_ready <= 1'b0;
      hub75_clk   <= 1'b0;
      hub75_latch <= 1'b0;
      hub75_oe_n  <= 1'b1;
      unique case (state)
        S_REQ: begin
          hub75_ready <= 1'b1;
          to_cnt      <= '0;
          state       <= S_WAIT;
        end
        // A strobe coinciding with timeout expiry is still captured
        S_WAIT: begin
          if (data_valid) begin
            plane <= '0;
            pix   <= PIX_LAST;
            phase <= 1'b0;
            state <= S_SHIFT;
          end else if (to_cnt == TO_LAST) begin
            state <= S_REQ;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        S_SHIFT: begin
          hub75_clk  <= phase;
          hub75_rgb0 <= {px0_c[r_idx_c], px0_c[g_idx_c], px0_c[b_idx_c]};
          hub75_rgb1 <= {px1_c[r_idx_c], px1_c[g_idx_c], px1_c[b_idx_c]};
          phase      <= ~phase;
          if (phase) begin
            if (pix == '0) begin
              state <= S_LATCH;
            end else begin
              pix <= pix - PW'(1);
            end
          end
        end
        S_LATCH: begin
          hub75_latch <= 1'b1;
          hub75_addr  <= addr_buf;
          disp_cnt    <= '0;
          state       <= S_DISPLAY;
        end
        S_DISPLAY: begin
          hub75_oe_n <= 1'b0;
          if (disp_cnt == disp_last_c) begin
            if (plane == 2'd2) begin
              state <= S_REQ;
            end else begin
              plane <= plane + 2'd1;
              pix   <= PIX_LAST;
              phase <= 1'b0;
              state <= S_SHIFT;
            end
          end else begin
            disp_cnt <= disp_cnt + DW'(1);
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule
